narrow_32x26: RTL

Pipelined 32-to-26-bit signed narrowing unit: the inverse of the 26-to-32 sign extender. It takes a 32-bit signed jump/branch displacement from the address-generation path. It emits the 26-bit instruction field plus an overflow flag. It sits between the target-address calculator and the instruction re-encoder / trace writer, with valid/ready handshakes on both sides. For every non-overflowing input, sign-extending Output_26 back to 32 bits reproduces Input_32 exactly.

---
 rtl/narrow_32x26.sv | 126 ++++++++++++
 1 files changed

// File: rtl/narrow_32x26.sv
`timescale 1ns/1ps
// narrow_32x26: two-stage pipelined signed narrowing of an IN_W-bit
// displacement to an OUT_W-bit field. The unit flags values that do not fit,
// and saturates or truncates them.
// Ports:
//   clk, reset          clock, async active-high reset
//   In_Valid/In_Ready   input handshake; Input_32 is the value to narrow
//   Out_Valid/Out_Ready output handshake; Output_26 and Out_Overflow are registered
//   Clear_Count         synchronous clear of Overflow_Count
//   Overflow_Count      saturating count of delivered overflowing results
module narrow_32x26 #(
  parameter int unsigned IN_W     = 32,
  parameter int unsigned OUT_W    = 26,
  parameter int unsigned SATURATE = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [IN_W-1:0]  Input_32,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [OUT_W-1:0] Output_26,
  output logic             Out_Overflow,
  input  logic             Clear_Count,
  output logic [CNT_W-1:0] Overflow_Count
);

  // Bits that must all equal the sign bit for the value to fit in OUT_W.
  localparam int unsigned HI_W = IN_W - OUT_W + 1;

  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              s1_valid_q, s1_valid_d;
  logic [IN_W-1:0]   s1_data_q,  s1_data_d;
  logic              s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0]  s2_data_q,  s2_data_d;
  logic              s2_ovf_q,   s2_ovf_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  logic              s2_load_c;
  logic              accept_c;
  logic              deliver_c;
  logic [HI_W-1:0]   hi_c;
  logic              ovf_c;
  logic [OUT_W-1:0]  result_c;

  // Handshake: S2 refills whenever it is empty or being drained; only comb path.
  always_comb begin
    s2_load_c = !s2_valid_q || Out_Ready;
    In_Ready  = !s1_valid_q || s2_load_c;
    accept_c  = In_Valid && In_Ready;
    deliver_c = s2_valid_q && Out_Ready;
  end

  // Representability check and result selection on the S1 value.
  always_comb begin
    hi_c     = s1_data_q[IN_W-1:OUT_W-1];
    ovf_c    = !((&hi_c) || !(|hi_c));
    result_c = s1_data_q[OUT_W-1:0];
    if (ovf_c && (SATURATE != 0)) begin
      result_c = s1_data_q[IN_W-1] ? SAT_MIN : SAT_MAX;
    end
  end

  // Next-state for both pipeline stages and the overflow counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_ovf_d   = s2_ovf_q;
    cnt_d      = cnt_q;

    if (accept_c) begin
      s1_valid_d = 1'b1;
      s1_data_d  = Input_32;
    end else if (s2_load_c) begin
      s1_valid_d = 1'b0;
    end

    // Payload only moves with a real item so outputs stay put across bubbles.
    if (s2_load_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = result_c;
        s2_ovf_d  = ovf_c;
      end
    end

    // Clear wins over a coincident overflowing delivery.
    if (Clear_Count) begin
      cnt_d = '0;
    end else if (deliver_c && s2_ovf_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_ovf_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_ovf_q   <= s2_ovf_d;
      cnt_q      <= cnt_d;
    end
  end

  assign Out_Valid      = s2_valid_q;
  assign Output_26      = s2_data_q;
  assign Out_Overflow   = s2_ovf_q;
  assign Overflow_Count = cnt_q;

endmodule
